// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC-3 branch-resolution datapath.
package lc3_pkg;

  typedef enum logic [1:0] {BR_IDLE, BR_EVAL, BR_REDIRECT} br_state_t;

  localparam logic [3:0] OP_BR = 4'b0000;

  function automatic logic [15:0] sext9(input logic [8:0] off);
    return {{7{off[8]}}, off};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Resolves LC-3 BR instructions against the NZP flags and offers the PC-relative
// target to the PC stage over a valid/ready handshake; keeps taken/not-taken stats.
module br_resolve_unit
  import lc3_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PC_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [PC_W-1:0]  IR,
  input  logic [PC_W-1:0]  PC,
  input  logic             Nin,
  input  logic             Zin,
  input  logic             Pin,
  input  logic             redirect_ready,
  input  logic             clr_stats,
  output logic             busy,
  output logic             ben,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_target,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  br_state_t       state, state_nxt;
  logic [2:0]      mask_q;
  logic [8:0]      offset_q;
  logic [PC_W-1:0] pc_q;
  logic            br_taken;
  logic            handshake;
  logic            taken_inc;
  logic            nt_inc;

  // The opcode is decoded upstream; start alone qualifies IR as a BR.
  logic unused_opcode;
  assign unused_opcode = (IR[PC_W-1:12] != OP_BR);

  // Flags are sampled live during EVAL, one cycle after start.
  assign br_taken       = |(mask_q & {Nin, Zin, Pin});
  assign busy           = (state != BR_IDLE);
  assign redirect_valid = (state == BR_REDIRECT);
  assign handshake      = redirect_valid & redirect_ready;
  assign taken_inc      = handshake;
  assign nt_inc         = (state == BR_EVAL) & ~br_taken;

  // NOTE: next_state gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      BR_IDLE:     if (start)     state_nxt = BR_EVAL;
      BR_EVAL:     state_nxt = br_taken ? BR_REDIRECT : BR_IDLE;
      BR_REDIRECT: if (redirect_ready) state_nxt = BR_IDLE;
      default:     state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= BR_IDLE;
      mask_q          <= '0;
      offset_q        <= '0;
      pc_q            <= '0;
      ben             <= 1'b0;
      redirect_target <= '0;
      done            <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        BR_IDLE: begin
          if (start) begin
            mask_q   <= IR[11:9];
            offset_q <= IR[8:0];
            pc_q     <= PC;
          end
        end
        BR_EVAL: begin
          ben             <= br_taken;
          redirect_target <= pc_q + PC_W'(sext9(offset_q));
          if (!br_taken) done <= 1'b1;
        end
        BR_REDIRECT: begin
          if (redirect_ready) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (clr_stats),
    .inc   (taken_inc),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_nt_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (clr_stats),
    .inc   (nt_inc),
    .count (nt_cnt)
  );

  a_target_stable: assert property (@(posedge Clk) disable iff (Reset)
    (redirect_valid && !redirect_ready) |=> (redirect_valid && $stable(redirect_target)));

  a_done_pulse: assert property (@(posedge Clk) disable iff (Reset)
    done |=> !done);

endmodule

// File: tb/tb_br_resolve_unit.sv
// Randomized scoreboard bench for br_resolve_unit with a spec-level reference model.
module tb_br_resolve_unit;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      IR = '0;
  logic [15:0]      PC = '0;
  logic             Nin = 1'b0, Zin = 1'b0, Pin = 1'b0;
  logic             redirect_ready = 1'b0;
  logic             clr_stats = 1'b0;
  logic             busy, ben, redirect_valid, done;
  logic [15:0]      redirect_target;
  logic [CNT_W-1:0] taken_cnt, nt_cnt;

  br_resolve_unit #(.CNT_W(CNT_W), .PC_W(16)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .start           (start),
    .IR              (IR),
    .PC              (PC),
    .Nin             (Nin),
    .Zin             (Zin),
    .Pin             (Pin),
    .redirect_ready  (redirect_ready),
    .clr_stats       (clr_stats),
    .busy            (busy),
    .ben             (ben),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .done            (done),
    .taken_cnt       (taken_cnt),
    .nt_cnt          (nt_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        taken;
    logic [15:0] target;
    int          tk;
    int          nt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_tk     = 0;
  int   m_nt     = 0;
  bit   seen_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Target is PC plus the signed 9-bit offset, modulo 2^16.
  function automatic logic [15:0] ref_target(input logic [15:0] pc, input logic [15:0] ir);
    int off;
    off = int'(ir[8:0]);
    if (off >= 256) off = off - 512;
    return 16'((int'(pc) + off) & 32'hFFFF);
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic run_branch(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                            input int ready_delay, input bit clr_at_hs, input bit extra_start);
    exp_t e;
    logic taken;
    taken = 1'b0;
    for (int k = 0; k < 3; k++)
      if (ir[9+k] && nzp[k]) taken = 1'b1;
    if (taken) begin
      if (clr_at_hs) begin
        m_tk = 0;
        m_nt = 0;
      end else begin
        m_tk = sat_inc(m_tk);
      end
    end else begin
      m_nt = sat_inc(m_nt);
    end
    e = '{taken, ref_target(pc, ir), m_tk, m_nt};
    exp_q.push_back(e);

    @(posedge Clk); #1;
    start = 1'b1; IR = ir; PC = pc; {Nin, Zin, Pin} = nzp;
    redirect_ready = (ready_delay == 0);
    @(posedge Clk); #1;
    start = 1'b0; IR = 16'($urandom); PC = 16'($urandom);
    check("busy_in_eval", {31'd0, busy}, 32'd1);
    @(posedge Clk); #1;
    {Nin, Zin, Pin} = 3'($urandom);
    check("valid_latency", {31'd0, redirect_valid}, {31'd0, taken});
    if (!taken) begin
      check("done_nt", {31'd0, done}, 32'd1);
      check("idle_nt", {31'd0, busy}, 32'd0);
    end else begin
      for (int i = 0; i < ready_delay; i++) begin
        if (extra_start && i == 0) begin
          start = 1'b1; IR = 16'h0FAA; PC = 16'($urandom);
        end
        @(posedge Clk); #1;
        start = 1'b0;
        check("valid_held", {31'd0, redirect_valid}, 32'd1);
      end
      redirect_ready = 1'b1;
      clr_stats = clr_at_hs;
      if (extra_start && ready_delay == 0) begin
        start = 1'b1; IR = 16'h0E40;
      end
      @(posedge Clk); #1;
      start = 1'b0; redirect_ready = 1'b0; clr_stats = 1'b0;
      check("done_taken", {31'd0, done}, 32'd1);
      check("valid_drop", {31'd0, redirect_valid}, 32'd0);
      check("idle_taken", {31'd0, busy}, 32'd0);
    end
    redirect_ready = 1'b0;
  endtask

  // Monitor: compares every presented redirect and every retirement against the queue.
  always begin
    @(negedge Clk);
    if (Reset) begin
      exp_q.delete();
      seen_valid = 1'b0;
    end else begin
      if (redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_unexpected", {31'd0, redirect_valid}, 32'd0);
        end else begin
          check("valid_vs_taken", {31'd0, redirect_valid}, {31'd0, exp_q[0].taken});
          check("target", {16'd0, redirect_target}, {16'd0, exp_q[0].target});
          seen_valid = 1'b1;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ben", {31'd0, ben}, {31'd0, e.taken});
          check("taken_cnt", 32'(taken_cnt), e.tk);
          check("nt_cnt", 32'(nt_cnt), e.nt);
          check("redirect_seen", {31'd0, seen_valid}, {31'd0, e.taken});
          seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_valid"},  {31'd0, redirect_valid}, 32'd0);
    check({tag, "_ben"},    {31'd0, ben}, 32'd0);
    check({tag, "_done"},   {31'd0, done}, 32'd0);
    check({tag, "_target"}, {16'd0, redirect_target}, 32'd0);
    check({tag, "_tk"},     32'(taken_cnt), 32'd0);
    check({tag, "_nt"},     32'(nt_cnt), 32'd0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("por");
    Reset = 1'b0;

    // Taken BRnzp with Z, ready already high.
    run_branch(16'h0E05, 16'h3000, 3'b010, 0, 1'b0, 1'b0);
    check("t2_taken_cnt", 32'(taken_cnt), 32'd1);
    // BRn with P set: not taken.
    run_branch(16'h0805, 16'h3000, 3'b001, 0, 1'b0, 1'b0);
    check("t3_nt_cnt", 32'(nt_cnt), 32'd1);
    // Back-pressure with a stray start during REDIRECT.
    run_branch(16'h0E05, 16'h4000, 3'b100, 3, 1'b0, 1'b1);
    // Wrap-around targets.
    run_branch(16'h0E03, 16'hFFFE, 3'b001, 0, 1'b0, 1'b0);
    run_branch(16'h0F00, 16'h0010, 3'b010, 1, 1'b0, 1'b0);
    // NOP mask and all-zero flags both fall through.
    run_branch(16'h0005, 16'h1234, 3'b111, 0, 1'b0, 1'b0);
    run_branch(16'h0E05, 16'h1234, 3'b000, 0, 1'b0, 1'b0);

    // Saturation then clear racing a handshake.
    for (int i = 0; i < 4; i++)
      run_branch(16'h0E10, 16'(16'h2000 + i), 3'b100, i % 2, 1'b0, 1'b0);
    check("sat_taken_cnt", 32'(taken_cnt), CMAX);
    run_branch(16'h0E10, 16'h2100, 3'b010, 0, 1'b1, 1'b0);
    check("clr_taken_cnt", 32'(taken_cnt), 32'd0);

    // Asynchronous reset while a redirect is pending.
    e = '{1'b1, 16'h3005, 0, 0};
    exp_q.push_back(e);
    @(posedge Clk); #1;
    start = 1'b1; IR = 16'h0E05; PC = 16'h3000; {Nin, Zin, Pin} = 3'b010; redirect_ready = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    @(posedge Clk); #1;
    check("pre_reset_valid", {31'd0, redirect_valid}, 32'd1);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("mid");
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_tk = 0;
    m_nt = 0;

    for (int n = 0; n < 40; n++) begin
      run_branch({4'h0, 3'($urandom), 9'($urandom)}, 16'($urandom), 3'($urandom),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                 bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge Clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
